hdmi_period_scheduler: RTL and testbench
========================================

Name: hdmi_period_scheduler

Overview:
- Sits between the video timing/pixel source and the three TMDS channel encoders (ch0=B, ch1=G, ch2=R).
- Sequences HDMI period types for the encoders: control period, video preamble, video guard band and active video.
- Delays the pixel stream by a fixed look-ahead so the preamble and guard band can be inserted before each active line.
- Supplies guard-band override codes, time-aligned to the encoder outputs, for the downstream serializer mux.

Parameters:
- PRE_LEN, 8: video preamble length, cycles.
- GB_LEN, 2: video guard band length, cycles.
- ENC_LAT, 3: encoder pipeline latency, din to dout, cycles.
- MIN_CTRL, 4: minimum plain control cycles required before a preamble.

Ports:
- clkin  in  1  pixel clock.
- rstin  in  1  reset. Asynchronous, active-low.
- vid_de  in  1  source data enable.
- vid_hs  in  1  source hsync.
- vid_vs  in  1  source vsync.
- vid_rgb  in  24  source pixel {R,G,B}.
- enc_din  out  24  encoder data {ch2,ch1,ch0}.
- enc_de  out  1  encoder de, common to all channels.
- enc_c  out  6  {ch2.c1,ch2.c0,ch1.c1,ch1.c0,ch0.c1,ch0.c0}.
- gb_active  out  1  select guard-band code instead of encoder dout; aligned to dout.
- gb_code  out  30  {ch2,ch1,ch0} 10-bit guard-band codes, valid while gb_active=1.
- state_o  out  2  0=CTRL, 1=PRE, 2=GUARD, 3=VIDEO (output timeline).
- err_short_blank  out  1  sticky: a preamble was skipped because blanking was too short.

Behaviour:
- Reset: all outputs 0; state CTRL; delay lines cleared (de=0, hs=vs=0); blank counter saturated (the first line is legal); err_short_blank=0.
- LOOKAHEAD = PRE_LEN+GB_LEN. Each input cycle's de/hs/vs/rgb passes through a LOOKAHEAD-deep register line; all enc_* outputs are registered at its tail.
  - Total latency, input to enc_*: LOOKAHEAD cycles.
  - gb_active and gb_code are delayed a further ENC_LAT cycles so they line up with encoder dout.
- Channel 0 control: enc_c[1:0] = {vs,hs} from the delayed line in every non-VIDEO state.
- CTL0..3 map to ch1.c0, ch1.c1, ch2.c0, ch2.c1:
  - CTRL: all CTL = 0.
  - PRE: CTL0..3 = 1,0,0,0.
  - GUARD, VIDEO: CTL undriven by this block; drive 0.
- blank_cnt: 5-bit saturating counter, cleared on every input cycle with vid_de=1, incremented on vid_de=0.
- Accepted rise: a 0->1 edge on vid_de with blank_cnt >= LOOKAHEAD+MIN_CTRL. On acceptance, a down-counter loads LOOKAHEAD and decrements each cycle; it schedules the output timeline.
- Output state machine (one state per output cycle):
  - CTRL -> PRE when the scheduled countdown reaches the preamble start. The first PRE cycle is exactly LOOKAHEAD cycles before delayed de rises.
  - PRE (PRE_LEN cycles) -> GUARD.
  - GUARD (GB_LEN cycles): enc_de=0, enc_din=0, gb_active pulses (delayed by ENC_LAT).
  - GUARD -> VIDEO when delayed de=1: enc_de=1, enc_din=delayed rgb.
  - VIDEO -> CTRL on the first cycle delayed de=0.
- Rejected rise (blank_cnt too small): no PRE or GUARD; state goes CTRL -> VIDEO directly when delayed de rises; err_short_blank set (sticky, cleared only by reset).
- gb_code constants: ch0=10'b1011001100, ch1=10'b0100110011, ch2=10'b1011001100.
- A vid_de drop during a scheduled PRE/GUARD: the timeline continues; VIDEO is simply short. No state jumps backward.
- vid_de held 1 through reset release: no accepted rise until the next 0->1 edge after the counter saturates.
- Reset mid-line: immediate return to the reset state; the encoder emits CTRLTOKEN0 until resync.

Optional Feature:
- HDMI_GUARD_EN defined: preamble and guard-band insertion as above.
- HDMI_GUARD_EN undefined (DVI mode):
  - state never enters PRE or GUARD.
  - CTL bits are always 0; gb_active=0 and gb_code=0.
  - err_short_blank is tied 0.
  - Latency stays LOOKAHEAD, so downstream alignment is unchanged.

Test Plan:
- Reset check: rstin low for 5 cycles mid-stream -> all outputs 0, state_o=0; after release, first line still gets a full preamble.
- Single line: blank 40 cycles, vid_de high 16 cycles, rgb incrementing from 24'h000001. Expect:
  - enc_c[3:2]=2'b01 and enc_c[5:4]=0 for 8 cycles;
  - then 2 GUARD cycles;
  - enc_de high 16 cycles with enc_din=24'h000001 exactly 10 cycles after input;
  - gb_active high for 2 cycles, 3 cycles after GUARD begins on enc_*.
- hsync/vsync passthrough: toggle vid_hs and vid_vs during blank -> enc_c[1:0] follows {vs,hs} 10 cycles later, including during PRE.
- Short blank: 10-cycle blank between lines -> no PRE/GUARD before the second line, err_short_blank=1 and stays 1 until reset.
- Boundary: blank exactly 14 cycles -> preamble inserted and no error; blank 13 cycles -> skipped and error set.
- DVI build (macro undefined): same stimulus as the single-line test -> state_o toggles only between 0 and 3, gb_active never 1, enc_din latency still 10.

Source files
------------

// File: rtl/hdmi_period_scheduler.sv
// HDMI period sequencer: control, preamble, guard band and video timeline for three TMDS encoders.
// Latency: LOOKAHEAD (PRE_LEN+GB_LEN) cycles to enc_*, plus ENC_LAT more to gb_*. No backpressure, one pixel per clkin.
// Define HDMI_GUARD_EN for preamble/guard insertion; leave it undefined for plain DVI sequencing.
module hdmi_period_scheduler #(
    parameter int PRE_LEN  = 8,
    parameter int GB_LEN   = 2,
    parameter int ENC_LAT  = 3,
    parameter int MIN_CTRL = 4
) (
    input  logic        clkin,
    input  logic        rstin,
    input  logic        vid_de,
    input  logic        vid_hs,
    input  logic        vid_vs,
    input  logic [23:0] vid_rgb,
    output logic [23:0] enc_din,
    output logic        enc_de,
    output logic [5:0]  enc_c,
    output logic        gb_active,
    output logic [29:0] gb_code,
    output logic [1:0]  state_o,
    output logic        err_short_blank
);
    localparam int LOOKAHEAD = PRE_LEN + GB_LEN;
    localparam int SCH_W     = $clog2(LOOKAHEAD + 1);
    localparam logic [4:0]       BLANK_MIN = 5'(LOOKAHEAD + MIN_CTRL);
    localparam logic [SCH_W-1:0] SCH_LOAD  = SCH_W'(LOOKAHEAD);
    localparam logic [SCH_W-1:0] SCH_GB    = SCH_W'(GB_LEN);
    localparam logic [SCH_W-1:0] SCH_ONE   = SCH_W'(1);
    localparam logic [29:0]      GB_CODES  = {10'b1011001100, 10'b0100110011, 10'b1011001100};

`ifdef HDMI_GUARD_EN
    localparam logic GUARD_EN = 1'b1;
`else
    localparam logic GUARD_EN = 1'b0;
`endif

    typedef struct packed {
        logic        de;
        logic        vs;
        logic        hs;
        logic [23:0] rgb;
    } pix_t;

    typedef enum logic [1:0] {ST_CTRL = 2'd0, ST_PRE = 2'd1, ST_GUARD = 2'd2, ST_VIDEO = 2'd3} state_t;

    pix_t             line_q [LOOKAHEAD];
    pix_t             line_d [LOOKAHEAD];
    pix_t             tail;
    logic             de_prev_q, de_prev_d;
    logic [4:0]       blank_cnt_q, blank_cnt_d;
    logic [SCH_W-1:0] sched_q, sched_d;
    state_t           state_q, state_d;
    logic [23:0]      enc_din_q, enc_din_d;
    logic             enc_de_q, enc_de_d;
    logic [5:0]       enc_c_q, enc_c_d;
    logic [ENC_LAT-1:0] gb_sr_q, gb_sr_d;
    logic             err_q, err_d;
    logic             rise, accept;

    assign tail = line_q[LOOKAHEAD-1];

    always_comb begin
        line_d[0] = '{de: vid_de, vs: vid_vs, hs: vid_hs, rgb: vid_rgb};
        for (int i = 1; i < LOOKAHEAD; i++) begin
            line_d[i] = line_q[i-1];
        end

        // de_prev resets high so a de held across reset release is not taken as a fresh line start
        de_prev_d   = vid_de;
        rise        = vid_de & ~de_prev_q;
        blank_cnt_d = vid_de ? 5'd0 : ((blank_cnt_q == 5'h1f) ? blank_cnt_q : blank_cnt_q + 5'd1);
        accept      = GUARD_EN & rise & (blank_cnt_q >= BLANK_MIN);
        err_d       = err_q | (GUARD_EN & rise & (blank_cnt_q < BLANK_MIN));

        // Countdown value for the cycle being registered: LOOKAHEAD..GB_LEN+1 is preamble, GB_LEN..1 guard
        sched_d = accept ? SCH_LOAD : ((sched_q != '0) ? sched_q - SCH_ONE : '0);

        if (sched_d > SCH_GB)       state_d = ST_PRE;
        else if (sched_d != '0)     state_d = ST_GUARD;
        else if (tail.de)           state_d = ST_VIDEO;
        else                        state_d = ST_CTRL;

        enc_de_d  = (state_d == ST_VIDEO);
        enc_din_d = (state_d == ST_VIDEO) ? tail.rgb : 24'd0;
        enc_c_d   = {3'b000, (state_d == ST_PRE),
                     (state_d == ST_VIDEO) ? 2'b00 : {tail.vs, tail.hs}};

        gb_sr_d[0] = (state_q == ST_GUARD);
        for (int i = 1; i < ENC_LAT; i++) begin
            gb_sr_d[i] = gb_sr_q[i-1];
        end
    end

    always_ff @(posedge clkin or negedge rstin) begin
        if (!rstin) begin
            for (int i = 0; i < LOOKAHEAD; i++) begin
                line_q[i] <= '0;
            end
            de_prev_q   <= 1'b1;
            blank_cnt_q <= 5'h1f;
            sched_q     <= '0;
            state_q     <= ST_CTRL;
            enc_din_q   <= '0;
            enc_de_q    <= 1'b0;
            enc_c_q     <= '0;
            gb_sr_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            line_q      <= line_d;
            de_prev_q   <= de_prev_d;
            blank_cnt_q <= blank_cnt_d;
            sched_q     <= sched_d;
            state_q     <= state_d;
            enc_din_q   <= enc_din_d;
            enc_de_q    <= enc_de_d;
            enc_c_q     <= enc_c_d;
            gb_sr_q     <= gb_sr_d;
            err_q       <= err_d;
        end
    end

    assign enc_din         = enc_din_q;
    assign enc_de          = enc_de_q;
    assign enc_c           = enc_c_q;
    assign gb_active       = gb_sr_q[ENC_LAT-1];
    assign gb_code         = gb_sr_q[ENC_LAT-1] ? GB_CODES : 30'd0;
    assign state_o         = state_q;
    assign err_short_blank = err_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Bench for hdmi_period_scheduler: random line/blank streams scored against a timeline model.
module tb_hdmi_period_scheduler;
    localparam int PRE_LEN  = 8;
    localparam int GB_LEN   = 2;
    localparam int ENC_LAT  = 3;
    localparam int MIN_CTRL = 4;
    localparam int LA       = PRE_LEN + GB_LEN;
    localparam int MAXC     = 4096;
    localparam logic [29:0] GB_CODES = {10'b1011001100, 10'b0100110011, 10'b1011001100};
`ifdef HDMI_GUARD_EN
    localparam bit HDMI = 1'b1;
`else
    localparam bit HDMI = 1'b0;
`endif

    logic        clkin = 1'b0;
    logic        rstin;
    logic        vid_de, vid_hs, vid_vs;
    logic [23:0] vid_rgb;
    logic [23:0] enc_din;
    logic        enc_de;
    logic [5:0]  enc_c;
    logic        gb_active;
    logic [29:0] gb_code;
    logic [1:0]  state_o;
    logic        err_short_blank;

    always #5 clkin = ~clkin;

    hdmi_period_scheduler #(
        .PRE_LEN(PRE_LEN), .GB_LEN(GB_LEN), .ENC_LAT(ENC_LAT), .MIN_CTRL(MIN_CTRL)
    ) dut (
        .clkin(clkin), .rstin(rstin),
        .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_rgb(vid_rgb),
        .enc_din(enc_din), .enc_de(enc_de), .enc_c(enc_c),
        .gb_active(gb_active), .gb_code(gb_code),
        .state_o(state_o), .err_short_blank(err_short_blank)
    );

    // Input history since the last reset release, plus the expected period of each output cycle
    logic        h_de [MAXC];
    logic        h_hs [MAXC];
    logic        h_vs [MAXC];
    logic [23:0] h_rgb[MAXC];
    logic        acc  [MAXC];
    int          x_st [MAXC];
    int          cyc;
    logic        err_exp;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int blank_before(input int n);
        int b = 0;
        for (int j = n - 1; j >= 0; j--) begin
            if (h_de[j]) return b;
            b++;
        end
        return 1000;
    endfunction

    task automatic step(input logic de, input logic hs, input logic vs, input logic [23:0] rgb);
        int          st;
        logic [23:0] x_din;
        logic [5:0]  x_c;
        logic        x_gb;
        logic        rise;
        @(negedge clkin);
        if (cyc >= MAXC) begin
            $display("FAIL history cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1);
        end
        vid_de = de; vid_hs = hs; vid_vs = vs; vid_rgb = rgb;
        h_de[cyc] = de; h_hs[cyc] = hs; h_vs[cyc] = vs; h_rgb[cyc] = rgb;

        rise = 1'b0;
        if (cyc > 0) rise = de && !h_de[cyc-1];
        acc[cyc] = HDMI && rise && (blank_before(cyc) >= LA + MIN_CTRL);
        if (HDMI && rise && (blank_before(cyc) < LA + MIN_CTRL)) err_exp = 1'b1;

        // A line start accepted at input cycle k owns outputs k..k+LA-1 (preamble then guard)
        st = 0;
        for (int j = LA - 1; j >= 0; j--) begin
            if (cyc - j >= 0) begin
                if (acc[cyc-j]) st = (j < PRE_LEN) ? 1 : 2;
            end
        end
        if (st == 0 && cyc >= LA) begin
            if (h_de[cyc-LA]) st = 3;
        end
        x_st[cyc] = st;

        x_din = 24'd0;
        x_c   = 6'd0;
        if (st == 3) x_din = h_rgb[cyc-LA];
        else if (cyc >= LA) x_c[1:0] = {h_vs[cyc-LA], h_hs[cyc-LA]};
        x_c[2] = (st == 1);
        x_gb = 1'b0;
        if (cyc >= ENC_LAT) x_gb = (x_st[cyc-ENC_LAT] == 2);

        @(posedge clkin);
        #1;
        check("state",   32'(state_o),         32'(st));
        check("enc_de",  32'(enc_de),          32'(st == 3));
        check("enc_din", 32'(enc_din),         32'(x_din));
        check("enc_c",   32'(enc_c),           32'(x_c));
        check("gb_act",  32'(gb_active),       32'(x_gb));
        check("gb_code", 32'(gb_code),         x_gb ? 32'(GB_CODES) : 32'd0);
        check("err",     32'(err_short_blank), 32'(err_exp));
        cyc++;
    endtask

    task automatic do_reset(input logic de_hold);
        @(negedge clkin);
        rstin = 1'b0; vid_de = de_hold; vid_hs = 1'b1; vid_vs = 1'b1; vid_rgb = 24'hABCDEF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clkin);
            #1;
            check("rst_state", 32'(state_o), 32'd0);
            check("rst_enc", {enc_din, enc_de, enc_c, 1'b0}, 32'd0);
            check("rst_gb", {1'b0, gb_active, gb_code}, 32'd0);
            check("rst_err", 32'(err_short_blank), 32'd0);
        end
        rstin = 1'b1;
        cyc = 0;
        err_exp = 1'b0;
    endtask

    task automatic run_line(input int blank, input int act, input logic [23:0] rgb0, input bit rnd);
        for (int i = 0; i < blank; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom));
        for (int i = 0; i < act; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 rnd ? 24'($urandom) : rgb0 + 24'(i));
    endtask

    initial begin
        rstin = 1'b0; vid_de = 1'b0; vid_hs = 1'b0; vid_vs = 1'b0; vid_rgb = 24'd0;
        cyc = 0; err_exp = 1'b0;
        do_reset(1'b0);

        run_line(40, 16, 24'h000001, 1'b0);   // single reference line
        run_line(10, 8, 24'h100000, 1'b0);    // too-short blank
        run_line(20, 6, 24'h200000, 1'b0);    // error stays sticky
        run_line(20, 4, 24'h300000, 1'b0);
        do_reset(1'b1);                       // reset mid-line
        run_line(5, 12, 24'h400000, 1'b0);    // counter saturated: full preamble
        run_line(14, 6, 24'h500000, 1'b0);    // boundary: accepted
        run_line(13, 6, 24'h600000, 1'b0);    // boundary: rejected
        run_line(20, 3, 24'h700000, 1'b0);    // de drops during guard timeline
        run_line(20, 1, 24'h710000, 1'b0);
        run_line(1, 5, 24'h720000, 1'b0);     // rise inside a running schedule
        run_line(25, 0, 24'h0, 1'b0);

        do_reset(1'b1);                       // de held across release
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 24'h800000 + 24'(i));
        run_line(20, 8, 24'h900000, 1'b0);

        for (int l = 0; l < 40; l++)
            run_line($urandom_range(1, 30), $urandom_range(1, 20), 24'd0, 1'b1);
        run_line(30, 0, 24'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
